// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage with IF/ID pipeline register. Holds
//               the PC, drives the instruction-memory address, latches the
//               fetched word, and applies control's redirect, stall and
//               bubble requests.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_sel_i,
    input  logic [31:0] alu_target_i,
    input  logic        insert_nop_i,
    input  logic        stall_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        misalign_o,
    output logic [15:0] bubble_cnt_o
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic [31:0] r_id_instr;
    logic        r_misalign;
    logic [15:0] r_bubble_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_load_bubble;

    // PC + 4 wraps naturally modulo 2^32; the target is forced word aligned.
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_redirect_pc = {alu_target_i[31:2], 2'b00};
    // A redirect always kills IF/ID; a NOP request only when not stalled.
    assign w_load_bubble = pc_sel_i | (~stall_i & insert_nop_i);

    // Program counter: redirect > stall > insert-NOP hold > sequential advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (pc_sel_i) begin
            r_pc <= w_redirect_pc;
        end else if (!stall_i && !insert_nop_i) begin
            r_pc <= w_pc_plus4;
        end
    end

    // IF/ID register: bubble on redirect or NOP request, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_id_pc    <= 32'd0;
            r_id_pc4   <= 32'd0;
            r_id_instr <= NOP_INSTR;
        end else if (w_load_bubble) begin
            r_valid    <= 1'b0;
            r_id_pc    <= 32'd0;
            r_id_pc4   <= 32'd0;
            r_id_instr <= NOP_INSTR;
        end else if (!stall_i) begin
            r_valid    <= 1'b1;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc_plus4;
            r_id_instr <= imem_rdata_i;
        end
    end

    // Sticky misalignment flag: a redirect target with bit 1 set is not
    // word aligned; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (pc_sel_i && alu_target_i[1]) begin
            r_misalign <= 1'b1;
        end
    end

    // Saturating count of bubbles loaded into IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= 16'd0;
        end else if (w_load_bubble && (r_bubble_cnt != C_CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign imem_addr_o   = r_pc;
    assign if_id_valid_o = r_valid;
    assign if_id_pc_o    = r_id_pc;
    assign if_id_pc4_o   = r_id_pc4;
    assign if_id_instr_o = r_id_instr;
    assign misalign_o    = r_misalign;
    assign bubble_cnt_o  = r_bubble_cnt;

endmodule
`default_nettype wire
